// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-control and control-bundle definitions for the
// five-stage pipeline control unit.
package cpu_pkg;

  localparam logic [3:0] OP_LW   = 4'd0;
  localparam logic [3:0] OP_SW   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Destination register is kept beside the bundle because its width is a
  // parameter of the unit.
  typedef struct packed {
    logic       regwr;
    logic       wbsel;
    logic       memwr;
    logic       memread;
    logic       alusrc;
    logic [2:0] aluctrl;
  } ctrl_t;

  function automatic logic [2:0] alu_ctrl_for(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_ctrl_for = ALU_SUB;
      OP_AND:  alu_ctrl_for = ALU_AND;
      OP_OR:   alu_ctrl_for = ALU_OR;
      OP_SLT:  alu_ctrl_for = ALU_SLT;
      default: alu_ctrl_for = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_hazard_detect.sv
// Combinational load-use and branch-operand hazard detection for the ID stage.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int RW = 3
) (
  input  logic          id_valid,
  input  logic [3:0]    id_op,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          ex_regwr,
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_dst,
  input  logic          mem_memread,
  input  logic [RW-1:0] mem_dst,
  output logic          load_use,
  output logic          br_haz,
  output logic          stall
);

  logic src_op;
  logic is_br;
  logic ex_hit;
  logic mem_hit;

  // Every defined opcode except J reads rs/rt in some form.
  assign src_op  = id_valid && (id_op <= OP_BNE) && (id_op != OP_J);
  assign is_br   = id_valid && ((id_op == OP_BEQ) || (id_op == OP_BNE));
  assign ex_hit  = (ex_dst == id_rs) || (ex_dst == id_rt);
  assign mem_hit = (mem_dst == id_rs) || (mem_dst == id_rt);

  assign load_use = src_op && ex_memread && ex_hit;
  assign br_haz   = is_br && ((ex_regwr && ex_hit) || (mem_memread && mem_hit));
  assign stall    = load_use || br_haz;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID decode, ID-stage branch resolution, hazard stall
// and the ID/EX, EX/MEM, MEM/WB control registers with event counters.
module pipe_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int RW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [3:0]    id_op,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          pc_src,
  output logic          if_flush,
  output logic          ex_alusrc,
  output logic [2:0]    ex_aluctrl,
  output logic [RW-1:0] ex_dst,
  output logic [RW-1:0] mem_dst,
  output logic          mem_wr,
  output logic          mem_read,
  output logic [RW-1:0] wb_dst,
  output logic          wb_regwr,
  output logic          wb_sel,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  ctrl_t         dec_ctrl;
  logic [RW-1:0] dec_dst;

  ctrl_t         idex_ctrl_q, idex_ctrl_d;
  logic [RW-1:0] idex_dst_q, idex_dst_d;
  logic          exmem_regwr_q, exmem_wbsel_q, exmem_memwr_q, exmem_memread_q;
  logic [RW-1:0] exmem_dst_q;
  logic          memwb_regwr_q, memwb_wbsel_q;
  logic [RW-1:0] memwb_dst_q;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  logic hz_stall, hz_load_use, hz_br_haz;
  logic hz_unused;
  logic taken;

  always_comb begin
    dec_ctrl = '0;
    dec_dst  = '0;
    if (id_valid) begin
      case (id_op)
        OP_LW: begin
          dec_ctrl.regwr   = 1'b1;
          dec_ctrl.memread = 1'b1;
          dec_ctrl.alusrc  = 1'b1;
          dec_dst          = id_rt;
        end
        OP_SW: begin
          dec_ctrl.memwr  = 1'b1;
          dec_ctrl.alusrc = 1'b1;
        end
        OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
          dec_ctrl.regwr   = 1'b1;
          dec_ctrl.wbsel   = 1'b1;
          dec_ctrl.alusrc  = (id_op == OP_ADDI);
          dec_ctrl.aluctrl = alu_ctrl_for(id_op);
          dec_dst          = id_rd;
        end
        default: ;
      endcase
    end
  end

  hazard_detect #(.RW(RW)) u_hazard (
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_regwr    (idex_ctrl_q.regwr),
    .ex_memread  (idex_ctrl_q.memread),
    .ex_dst      (idex_dst_q),
    .mem_memread (exmem_memread_q),
    .mem_dst     (exmem_dst_q),
    .load_use    (hz_load_use),
    .br_haz      (hz_br_haz),
    .stall       (hz_stall)
  );

  // The individual hazard causes are only of interest when probing the unit.
  assign hz_unused = hz_load_use ^ hz_br_haz;

  // Stall wins over resolution so a branch never redirects on stale operands.
  always_comb begin
    taken = 1'b0;
    if (id_valid && !hz_stall) begin
      case (id_op)
        OP_BEQ:  taken = (id_rdata1 == id_rdata2);
        OP_BNE:  taken = (id_rdata1 != id_rdata2);
        OP_J:    taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    idex_ctrl_d = hz_stall ? '0 : dec_ctrl;
    idex_dst_d  = hz_stall ? '0 : dec_dst;
    stall_cnt_d = (hz_stall && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CW'(1) : stall_cnt_q;
    flush_cnt_d = (taken && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + CW'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ctrl_q     <= '0;
      idex_dst_q      <= '0;
      exmem_regwr_q   <= 1'b0;
      exmem_wbsel_q   <= 1'b0;
      exmem_memwr_q   <= 1'b0;
      exmem_memread_q <= 1'b0;
      exmem_dst_q     <= '0;
      memwb_regwr_q   <= 1'b0;
      memwb_wbsel_q   <= 1'b0;
      memwb_dst_q     <= '0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      idex_ctrl_q     <= idex_ctrl_d;
      idex_dst_q      <= idex_dst_d;
      exmem_regwr_q   <= idex_ctrl_q.regwr;
      exmem_wbsel_q   <= idex_ctrl_q.wbsel;
      exmem_memwr_q   <= idex_ctrl_q.memwr;
      exmem_memread_q <= idex_ctrl_q.memread;
      exmem_dst_q     <= idex_dst_q;
      memwb_regwr_q   <= exmem_regwr_q;
      memwb_wbsel_q   <= exmem_wbsel_q;
      memwb_dst_q     <= exmem_dst_q;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign pc_write   = !hz_stall;
  assign ifid_write = !hz_stall;
  assign pc_src     = taken;
  assign if_flush   = taken;
  assign ex_alusrc  = idex_ctrl_q.alusrc;
  assign ex_aluctrl = idex_ctrl_q.aluctrl;
  assign ex_dst     = idex_dst_q;
  assign mem_dst    = exmem_dst_q;
  assign mem_wr     = exmem_memwr_q;
  assign mem_read   = exmem_memread_q;
  assign wb_dst     = memwb_dst_q;
  assign wb_regwr   = memwb_regwr_q;
  assign wb_sel     = memwb_wbsel_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Registered, parametrised control unit for the five-stage pipelined CPU. It decodes the ID-stage opcode and resolves BEQ/BNE/J in ID. It detects load-use and branch-operand hazards and stalls on them. Its ID/EX, EX/MEM and MEM/WB control registers drive the datapath muxes directly, so decode and hazard logic are no longer scattered across stage modules.

## Interface
Parameters:
- DW, 8, datapath width of compared register operands
- RW, 3, register-address width
- CW, 16, width of the stall and flush event counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction; 0 decodes as bubble
- id_op  in  4  opcode: 0 LW, 1 SW, 2 ADD, 3 ADDI, 4 SUB, 5 AND, 6 OR, 7 SLT, 8 BEQ, 9 J, 10 BNE, others NOP
- id_rs, id_rt, id_rd  in  RW  source and destination fields
- id_rdata1, id_rdata2  in  DW  register-file read data for rs and rt
- pc_write, ifid_write  out  1  0 = hold PC / IF/ID (stall)
- pc_src, if_flush  out  1  redirect PC to branch/jump target; zero IF/ID
- ex_alusrc  out  1  1 = immediate operand
- ex_aluctrl  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt
- ex_dst, mem_dst, wb_dst  out  RW  destination register per stage
- mem_wr, mem_read  out  1  data-memory strobes
- wb_regwr  out  1  register-file write enable
- wb_sel  out  1  0 = memory data, 1 = ALU result
- stall_cnt, flush_cnt  out  CW  saturating event counters

## Operation
Decode (combinational, ID):
- Bundle {regwr, wbsel, memwr, memread, alusrc, aluctrl, dst}.
- LW: regwr=1, wbsel=0, memread=1, alusrc=1, dst=rt.
- SW: memwr=1, alusrc=1.
- ADD/SUB/AND/OR/SLT: regwr=1, wbsel=1, alusrc=0, dst=rd, aluctrl per the table above.
- ADDI: regwr=1, wbsel=1, alusrc=1, dst=rd.
- BEQ, BNE, J and NOP: all-zero bundle.
- id_valid=0 forces an all-zero bundle.

Hazards (combinational):
- load_use = idex.memread & (ex_dst==id_rs | ex_dst==id_rt), for any valid non-J opcode.
- br_haz = (BEQ|BNE) & ((idex.regwr & ex_dst∈{rs,rt}) | (exmem.memread & mem_dst∈{rs,rt})).
- stall = load_use | br_haz.
- On stall: pc_write=0, ifid_write=0, and a zero bundle enters ID/EX next edge.

Branch resolution (ID, only when stall=0):
- BEQ taken iff id_rdata1==id_rdata2, full DW-bit compare.
- BNE taken iff id_rdata1!=id_rdata2.
- J is always taken.
- Taken: pc_src=1 and if_flush=1 in the same cycle.
- Stall has priority: with stall=1, pc_src=if_flush=0 even if the compare matches.

Pipeline and counters:
- Each rising edge: ID/EX ← (stall ? 0 : decode), EX/MEM ← ID/EX, MEM/WB ← EX/MEM (memory/WB fields only).
- The stage registers never hold, and flush never clears them.
- stall_cnt increments each stall cycle; flush_cnt increments each if_flush cycle.
- Both counters saturate at 2^CW−1 and never wrap.

## Timing
- Reset: all stage registers zero (bubbles), both counters zero.
- Outputs after reset:
  - Registered outputs 0: ex_*, mem_*, wb_*, counters.
  - pc_write=ifid_write=1 and pc_src=if_flush=0, as long as id_valid=0.
- Latency: decode appears on ex_* 1 cycle after ID, on mem_* after 2, on wb_* after 3.
- Load-use costs exactly 1 stall cycle.
- Branch after an ALU op writing its operand: 1 stall cycle.
- Branch after a LW writing its operand: 2 stall cycles (load_use, then the EX/MEM memread term).
- Taken branch or jump costs 1 flushed slot.
- Reset asserted mid-operation clears everything on that edge; no partial state survives.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams (OP_LW … OP_BNE)
  - ALU-control constants
  - the control-bundle struct/width
- `pipe_ctrl_unit` imports it.
- One sub-module: `hazard_detect`, purely combinational, producing stall, load_use and br_haz.
- Decode and stage registers stay in the top.

## Test plan
- Reset and defaults: rst held 2 cycles → all registered outputs 0, pc_write=1, counters 0.
- ADD r3 (id_rd=3) then idle → ex_aluctrl=0 at +1, mem_dst=3 at +2, wb_regwr=1, wb_sel=1, wb_dst=3 at +3.
- LW r2 then ADD using rs=2 → one cycle pc_write=ifid_write=0; bubble in ID/EX; stall_cnt=1; ADD reaches ex_* one cycle late.
- BEQ with rdata 8'h5A/8'h5A, no hazard → pc_src=if_flush=1 that cycle; flush_cnt=1.
- BNE with 8'h5A/8'h5A → not taken, pc_src=0.
- LW r1 then BEQ rs=1 → 2 stall cycles with pc_src held 0; resolves on cycle 3; stall_cnt=2.
- CW=2 with 5 stalls → stall_cnt sticks at 3.
